// File: rtl/planificador_semaforo.sv
// planificador_semaforo
// Phase scheduler for a two-approach intersection (A and B) with an exclusive
// pedestrian phase. Vehicle demand and latched pedestrian requests decide when
// a green phase ends. Phases run green -> yellow -> all-red and then either the
// opposite green or a pedestrian phase. All phase timing is counted in ticks
// produced by an internal prescaler.
//
// Ports:
//   clk                        system clock, rising edge
//   rst                        synchronous, active-high reset
//   SensorA, SensorB           vehicle present on approach A / B (level)
//   PasoA, PasoB               pedestrian pushbuttons (level or pulse)
//   VerdeA, AmarilloA, RojoA   approach A lamps (one-hot)
//   VerdeB, AmarilloB, RojoB   approach B lamps (one-hot)
//   CruceA, CruceB             walk indicators for requests served in PEATON
//   PendA, PendB               latched pedestrian requests
//   cuenta                     ticks remaining in the current phase
module planificador_semaforo #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int T_VERDE_MIN = 4,
  parameter int T_VERDE_MAX = 10,
  parameter int T_AMARILLO  = 3,
  parameter int T_ROJO      = 1,
  parameter int T_PEATON    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SensorA,
  input  logic       SensorB,
  input  logic       PasoA,
  input  logic       PasoB,
  output logic       VerdeA,
  output logic       AmarilloA,
  output logic       RojoA,
  output logic       VerdeB,
  output logic       AmarilloB,
  output logic       RojoB,
  output logic       CruceA,
  output logic       CruceB,
  output logic       PendA,
  output logic       PendB,
  output logic [3:0] cuenta
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0] C_VERDE    = 4'(T_VERDE_MAX - 1);
  localparam logic [3:0] C_AMARILLO = 4'(T_AMARILLO - 1);
  localparam logic [3:0] C_ROJO     = 4'(T_ROJO - 1);
  localparam logic [3:0] C_PEATON   = 4'(T_PEATON - 1);
  localparam logic [3:0] TV_MIN     = 4'(T_VERDE_MIN - 1);

  typedef enum logic [2:0] {
    VERDE_A, AMARILLO_A, ROJO_AB, VERDE_B, AMARILLO_B, ROJO_BA, PEATON
  } estado_t;

  estado_t       estado, estado_n;
  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    cuenta_q, cuenta_n;
  logic [3:0]    tv, tv_n;
  logic          sig, sig_n;
  logic          pend_a, pend_a_n, pend_b, pend_b_n;
  logic          cruce_a, cruce_a_n, cruce_b, cruce_b_n;
  logic          propio, demanda;

  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= VERDE_A;
      cuenta_q <= C_VERDE;
      tv       <= '0;
      sig      <= 1'b0;
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
      cruce_a  <= 1'b0;
      cruce_b  <= 1'b0;
    end else begin
      estado   <= estado_n;
      cuenta_q <= cuenta_n;
      tv       <= tv_n;
      sig      <= sig_n;
      pend_a   <= pend_a_n;
      pend_b   <= pend_b_n;
      cruce_a  <= cruce_a_n;
      cruce_b  <= cruce_b_n;
    end
  end

  // Own and opposing demand for whichever green is active; sensors are only
  // looked at on tick edges, so pulses between ticks never count.
  always_comb begin
    propio  = (estado == VERDE_A) ? SensorA : SensorB;
    demanda = ((estado == VERDE_A) ? SensorB : SensorA) | pend_a | pend_b;
  end

  always_comb begin
    estado_n  = estado;
    cuenta_n  = cuenta_q;
    tv_n      = tv;
    sig_n     = sig;
    pend_a_n  = pend_a | PasoA;
    pend_b_n  = pend_b | PasoB;
    cruce_a_n = cruce_a;
    cruce_b_n = cruce_b;
    if (tick) begin
      case (estado)
        VERDE_A, VERDE_B: begin
          if (demanda && (((tv >= TV_MIN) && !propio) || (cuenta_q == 4'd0))) begin
            estado_n = (estado == VERDE_A) ? AMARILLO_A : AMARILLO_B;
            cuenta_n = C_AMARILLO;
          end else begin
            cuenta_n = (cuenta_q == 4'd0) ? 4'd0 : cuenta_q - 4'd1;
            tv_n     = (tv == 4'd15) ? 4'd15 : tv + 4'd1;
          end
        end
        AMARILLO_A, AMARILLO_B: begin
          if (cuenta_q == 4'd0) begin
            estado_n = (estado == AMARILLO_A) ? ROJO_AB : ROJO_BA;
            cuenta_n = C_ROJO;
          end else begin
            cuenta_n = cuenta_q - 4'd1;
          end
        end
        ROJO_AB, ROJO_BA: begin
          if (cuenta_q != 4'd0) begin
            cuenta_n = cuenta_q - 4'd1;
          end else if (pend_a | pend_b) begin
            // A press arriving on this very edge is folded into the served
            // set rather than being re-latched for the next cycle.
            estado_n  = PEATON;
            cuenta_n  = C_PEATON;
            sig_n     = (estado == ROJO_AB);
            cruce_a_n = pend_a | PasoA;
            cruce_b_n = pend_b | PasoB;
            pend_a_n  = 1'b0;
            pend_b_n  = 1'b0;
          end else begin
            estado_n = (estado == ROJO_AB) ? VERDE_B : VERDE_A;
            cuenta_n = C_VERDE;
            tv_n     = 4'd0;
          end
        end
        PEATON: begin
          if (cuenta_q == 4'd0) begin
            estado_n  = sig ? VERDE_B : VERDE_A;
            cuenta_n  = C_VERDE;
            tv_n      = 4'd0;
            cruce_a_n = 1'b0;
            cruce_b_n = 1'b0;
          end else begin
            cuenta_n = cuenta_q - 4'd1;
          end
        end
        default: begin
          estado_n = VERDE_A;
          cuenta_n = C_VERDE;
          tv_n     = 4'd0;
        end
      endcase
    end
  end

  // Moore lamp decode: every non-green, non-yellow approach shows red.
  always_comb begin
    VerdeA    = (estado == VERDE_A);
    AmarilloA = (estado == AMARILLO_A);
    VerdeB    = (estado == VERDE_B);
    AmarilloB = (estado == AMARILLO_B);
    RojoA     = !(VerdeA | AmarilloA);
    RojoB     = !(VerdeB | AmarilloB);
  end

  assign CruceA = cruce_a & (estado == PEATON);
  assign CruceB = cruce_b & (estado == PEATON);
  assign PendA  = pend_a;
  assign PendB  = pend_b;
  assign cuenta = cuenta_q;

endmodule

// File: tb/tb_planificador_semaforo.sv
// tb_planificador_semaforo
// Bench for planificador_semaforo with TICK_DIV=4. Hand-derived vector table,
// directed pedestrian sequences, and a long random run, all while a
// phase/elapsed-time reference model is compared against the outputs on every
// falling edge.
module tb_planificador_semaforo;

  localparam int TICK_DIV = 4;
  localparam int VMIN = 4, VMAX = 10, TA = 3, TR = 1, TP = 6;
  localparam int K_GREEN = 0, K_YEL = 1, K_RED = 2, K_WALK = 3;

  logic clk = 1'b0;
  logic rst, sensorA, sensorB, pasoA, pasoB;
  logic verdeA, amarilloA, rojoA, verdeB, amarilloB, rojoB;
  logic cruceA, cruceB, pendA, pendB;
  logic [3:0] cuenta;

  int checks = 0;
  int errors = 0;
  bit checkOn = 1'b0;

  int mCur, mKind, mEl, mPresc;
  bit mPendA, mPendB, mSrvA, mSrvB;

  typedef struct {
    logic rst, sa, sb, pa, pb;
    int cycles;
    logic [5:0] lamps;
    logic [1:0] cruce;
    logic [1:0] pend;
    logic [3:0] cnt;
    string name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  planificador_semaforo #(
    .TICK_DIV(TICK_DIV), .T_VERDE_MIN(VMIN), .T_VERDE_MAX(VMAX),
    .T_AMARILLO(TA), .T_ROJO(TR), .T_PEATON(TP)
  ) dut (
    .clk(clk), .rst(rst), .SensorA(sensorA), .SensorB(sensorB),
    .PasoA(pasoA), .PasoB(pasoB),
    .VerdeA(verdeA), .AmarilloA(amarilloA), .RojoA(rojoA),
    .VerdeB(verdeB), .AmarilloB(amarilloB), .RojoB(rojoB),
    .CruceA(cruceA), .CruceB(cruceB), .PendA(pendA), .PendB(pendB),
    .cuenta(cuenta)
  );

  function automatic logic [15:0] dutVec();
    return {verdeA, amarilloA, rojoA, verdeB, amarilloB, rojoB,
            cruceA, cruceB, pendA, pendB, cuenta};
  endfunction

  // Reference: current approach, phase kind and ticks elapsed in the phase.
  function automatic logic [15:0] modelVec();
    logic va, aa, vb, ab;
    int rem;
    va = (mKind == K_GREEN) && (mCur == 0);
    vb = (mKind == K_GREEN) && (mCur == 1);
    aa = (mKind == K_YEL) && (mCur == 0);
    ab = (mKind == K_YEL) && (mCur == 1);
    case (mKind)
      K_GREEN: rem = (VMAX - 1 - mEl < 0) ? 0 : VMAX - 1 - mEl;
      K_YEL:   rem = TA - 1 - mEl;
      K_RED:   rem = TR - 1 - mEl;
      default: rem = TP - 1 - mEl;
    endcase
    return {va, aa, !(va | aa), vb, ab, !(vb | ab),
            mSrvA, mSrvB, mPendA, mPendB, 4'(rem)};
  endfunction

  task automatic modelStep();
    bit tk, own, dem, nA, nB;
    if (rst) begin
      mCur = 0; mKind = K_GREEN; mEl = 0; mPresc = 0;
      mPendA = 0; mPendB = 0; mSrvA = 0; mSrvB = 0;
      return;
    end
    tk = (mPresc == TICK_DIV - 1);
    mPresc = tk ? 0 : mPresc + 1;
    nA = mPendA | pasoA;
    nB = mPendB | pasoB;
    if (tk) begin
      case (mKind)
        K_GREEN: begin
          own = (mCur == 0) ? sensorA : sensorB;
          dem = ((mCur == 0) ? sensorB : sensorA) | mPendA | mPendB;
          if (dem && ((mEl >= VMIN - 1 && !own) || mEl >= VMAX - 1)) begin
            mKind = K_YEL; mEl = 0;
          end else mEl++;
        end
        K_YEL: if (mEl == TA - 1) begin mKind = K_RED; mEl = 0; end else mEl++;
        K_RED: begin
          if (mEl != TR - 1) mEl++;
          else if (mPendA | mPendB) begin
            mKind = K_WALK; mEl = 0;
            mSrvA = mPendA | pasoA; mSrvB = mPendB | pasoB;
            nA = 0; nB = 0;
          end else begin
            mKind = K_GREEN; mCur = 1 - mCur; mEl = 0;
          end
        end
        default: begin
          if (mEl == TP - 1) begin
            mKind = K_GREEN; mCur = 1 - mCur; mEl = 0; mSrvA = 0; mSrvB = 0;
          end else mEl++;
        end
      endcase
    end
    mPendA = nA;
    mPendB = nB;
  endtask

  // Reference model advances on the same edges as the design.
  always @(posedge clk) modelStep();

  // Continuous comparison against the reference model.
  always @(negedge clk) begin
    if (checkOn) begin
      checks++;
      if (dutVec() !== modelVec()) begin
        errors++;
        $display("[TB] FAIL model_compare t=%0t got=%b exp=%b", $time, dutVec(), modelVec());
      end
    end
  end

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] exp);
    checks++;
    if (dutVec() !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%b exp=%b", name, dutVec(), exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; sensorA = v.sa; sensorB = v.sb; pasoA = v.pa; pasoB = v.pb;
    runCycles(v.cycles);
  endtask

  task automatic setIn(input logic r, input logic sa, input logic sb,
                       input logic pa, input logic pb);
    rst = r; sensorA = sa; sensorB = sb; pasoA = pa; pasoB = pb;
  endtask

  initial begin
    // Lamps {VA,AA,RA,VB,AB,RB}; cruce {A,B}; pend {A,B}; edges counted from reset.
    vecs.push_back('{1, 0, 0, 0, 0,  1, 6'b100001, 2'b00, 2'b00, 4'd9, "reset_state"});
    vecs.push_back('{0, 1, 1, 0, 0, 39, 6'b100001, 2'b00, 2'b00, 4'd0, "green_a_before_maxout"});
    vecs.push_back('{0, 1, 1, 0, 0,  1, 6'b010001, 2'b00, 2'b00, 4'd2, "yellow_a_entry"});
    vecs.push_back('{0, 1, 1, 0, 0,  4, 6'b010001, 2'b00, 2'b00, 4'd1, "yellow_a_step"});
    vecs.push_back('{0, 1, 1, 0, 0,  8, 6'b001001, 2'b00, 2'b00, 4'd0, "rojo_ab"});
    vecs.push_back('{0, 1, 1, 0, 0,  4, 6'b001100, 2'b00, 2'b00, 4'd9, "green_b_entry"});
    vecs.push_back('{0, 0, 1, 0, 1,  1, 6'b001100, 2'b00, 2'b01, 4'd9, "pend_b_latch"});
    vecs.push_back('{0, 0, 0, 0, 0, 14, 6'b001100, 2'b00, 2'b01, 4'd6, "green_b_before_gapout"});
    vecs.push_back('{0, 0, 0, 0, 0,  1, 6'b001010, 2'b00, 2'b01, 4'd2, "yellow_b_gapout"});
    vecs.push_back('{0, 0, 0, 0, 0, 16, 6'b001001, 2'b01, 2'b00, 4'd5, "peaton_entry"});
    vecs.push_back('{0, 0, 0, 0, 0, 23, 6'b001001, 2'b01, 2'b00, 4'd0, "peaton_last"});
    vecs.push_back('{0, 0, 0, 0, 0,  1, 6'b100001, 2'b00, 2'b00, 4'd9, "green_a_after_walk"});
    vecs.push_back('{0, 1, 1, 0, 1, 42, 6'b010001, 2'b00, 2'b01, 4'd2, "yellow_a_second"});
    vecs.push_back('{1, 0, 0, 0, 0,  1, 6'b100001, 2'b00, 2'b00, 4'd9, "reset_mid_yellow"});
    vecs.push_back('{0, 0, 0, 0, 0,  3, 6'b100001, 2'b00, 2'b00, 4'd9, "no_tick_before_div"});
    vecs.push_back('{0, 0, 0, 0, 0,  1, 6'b100001, 2'b00, 2'b00, 4'd8, "first_tick"});

    setIn(1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOn = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, {vecs[i].lamps, vecs[i].cruce, vecs[i].pend, vecs[i].cnt});
    end

    // PasoA held across the ROJO_AB -> PEATON edge, then a press during PEATON.
    setIn(1, 0, 0, 0, 0); runCycles(1);
    setIn(0, 1, 1, 1, 0); runCycles(1);
    checkOutput("pend_a_latch", {6'b100001, 2'b00, 2'b10, 4'd9});
    runCycles(54);
    checkOutput("rojo_ab_pend_a", {6'b001001, 2'b00, 2'b10, 4'd0});
    runCycles(1);
    checkOutput("peaton_held_press", {6'b001001, 2'b10, 2'b00, 4'd5});
    pasoA = 0; runCycles(4);
    checkOutput("peaton_no_relatch", {6'b001001, 2'b10, 2'b00, 4'd4});
    pasoA = 1; runCycles(1);
    checkOutput("press_in_peaton", {6'b001001, 2'b10, 2'b10, 4'd4});
    pasoA = 0; runCycles(19);
    checkOutput("green_b_after_walk", {6'b001100, 2'b00, 2'b10, 4'd9});
    runCycles(56);
    checkOutput("second_peaton", {6'b001001, 2'b10, 2'b00, 4'd5});
    runCycles(24);
    checkOutput("green_a_after_second", {6'b100001, 2'b00, 2'b00, 4'd9});

    // No demand: green rests and the countdown parks at zero.
    setIn(1, 0, 0, 0, 0); runCycles(1);
    rst = 0; runCycles(36);
    checkOutput("rest_countdown_zero", {6'b100001, 2'b00, 2'b00, 4'd0});
    runCycles(120);
    checkOutput("rest_long", {6'b100001, 2'b00, 2'b00, 4'd0});

    // Random traffic, checked by the reference model each cycle.
    setIn(1, 0, 0, 0, 0); runCycles(1);
    rst = 0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(15) == 0) sensorA = ~sensorA;
      if ($urandom_range(15) == 0) sensorB = ~sensorB;
      pasoA = ($urandom_range(60) == 0);
      pasoB = ($urandom_range(60) == 0);
      rst   = ($urandom_range(1999) == 0);
      runCycles(1);
    end

    checkOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/planificador_semaforo.md
# planificador_semaforo

Phase scheduler for a two-approach intersection (approaches A and B) with an exclusive pedestrian phase. It arbitrates between vehicle sensor demand (SensorA, SensorB) and latched pedestrian pushbutton requests (PasoA, PasoB). It sequences green → yellow → all-red (→ pedestrian) phases using a tick-based down-counter, and drives the six lamp outputs plus the walk indicators. It replaces the fixed-cycle light sequencing at the top of the traffic-light design and exposes the phase countdown on `cuenta` for the display.

## Interface
- TICK_DIV, 50_000_000: clk cycles per timing tick; must be ≥2.
- T_VERDE_MIN, 4: minimum green, in ticks.
- T_VERDE_MAX, 10: maximum green under opposing demand, in ticks.
- T_AMARILLO, 3: yellow duration, in ticks.
- T_ROJO, 1: all-red clearance duration, in ticks.
- T_PEATON, 6: pedestrian phase duration, in ticks.
- All T_* parameters must lie in 1..15, with T_VERDE_MIN ≤ T_VERDE_MAX.
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- SensorA, SensorB  in  1  vehicle present on approach A / B (level).
- PasoA, PasoB  in  1  pedestrian button A / B (level or pulse; sampled every clk).
- VerdeA, AmarilloA, RojoA  out  1  approach A lamps (exactly one high).
- VerdeB, AmarilloB, RojoB  out  1  approach B lamps (exactly one high).
- CruceA, CruceB  out  1  walk indicators; high only in PEATON, and only for a served request.
- PendA, PendB  out  1  latched pedestrian requests.
- cuenta  out  4  ticks remaining in the current phase.

## Operation
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick` is high for one clk when the count equals TICK_DIV-1.
  - All timers advance only on tick.
- States: VERDE_A, AMARILLO_A, ROJO_AB, VERDE_B, AMARILLO_B, ROJO_BA, PEATON.
- A 1-bit `sig` register records which green follows PEATON: B after ROJO_AB, A after ROJO_BA.
- Lamp decode: each state drives its own colour on the named approach; the other approach is Rojo. ROJO_*, and PEATON, drive RojoA=RojoB=1.
- Timed phases (AMARILLO, ROJO, PEATON):
  - On entry, load cuenta=T-1.
  - On each tick, decrement; on a tick with cuenta=0, transition.
  - Each timed phase therefore lasts exactly T ticks.
- Green phase:
  - On entry, load cuenta=T_VERDE_MAX-1 and clear an internal elapsed counter `tv`.
  - On each tick, cuenta decrements and saturates at 0; `tv` increments and saturates at 15.
- Demand while in VERDE_A = SensorB | PendA | PendB; symmetric for VERDE_B.
- Leave green on a tick when demand=1 and either of:
  - (a) gap-out: `tv` ≥ T_VERDE_MIN-1 and own sensor = 0;
  - (b) max-out: cuenta = 0.
- With no demand, green rests indefinitely and cuenta holds 0.
- Transitions:
  - VERDE_A → AMARILLO_A → ROJO_AB → (PEATON if PendA|PendB, else VERDE_B).
  - VERDE_B → AMARILLO_B → ROJO_BA → (PEATON if PendA|PendB, else VERDE_A).
  - PEATON → green selected by `sig`.
- Pedestrian latch:
  - PendX is set on any clk where PasoX=1.
  - On the ROJO→PEATON edge, PendA/PendB are copied into served flags (CruceA/CruceB for the whole PEATON phase) and cleared.
  - A press on that same edge counts as served and is not re-latched.
  - Presses during PEATON latch normally for the next cycle.
- Reset:
  - Effective at any state, mid-phase included.
  - state=VERDE_A, cuenta=T_VERDE_MAX-1, `tv`=0, prescaler=0, PendA=PendB=0, Cruce*=0, sig=0.
- Reset values of outputs: VerdeA=1, RojoB=1, all other lamps 0, CruceA=CruceB=0, PendA=PendB=0, cuenta=T_VERDE_MAX-1.

## Timing
- The state, cuenta, Pend and Cruce registers update on the rising edge where tick=1 (Pend on any edge).
- Lamps are a Moore decode of the state register: they change immediately after the transition edge, with no extra cycle of latency.
- The first tick occurs TICK_DIV cycles after the edge on which rst is sampled low.
- PasoX high at edge n gives PendX=1 after edge n.
- PendX is considered in the demand term at the first tick after that.
- Sensors are sampled only on tick edges, with no latching; a sensor pulse that falls entirely between ticks is ignored.
- Simultaneous PasoA and PasoB: both are latched and both are served in one PEATON phase, so CruceA=CruceB=1.

## Test plan
Defaults apply, except TICK_DIV=4.
1. Reset, then all inputs 0 → VerdeA=RojoB=1. cuenta steps 9→0 over 9 ticks, then holds 0. VerdeA stays high for 30+ ticks.
2. SensorA=SensorB=1 held → VerdeA lasts 10 ticks (max-out). Then AmarilloA for 3 ticks (cuenta 2,1,0), ROJO_AB for 1 tick, then VerdeB=RojoA=1 with cuenta=9.
3. SensorB=1, SensorA=0 → gap-out: AmarilloA rises on the 4th tick edge after reset release (16 clk).
4. One-clk PasoB pulse during VERDE_A with SensorA=0 → PendB=1 on the next clk. The sequence is yellow 3 ticks, red 1 tick, then PEATON for 6 ticks with CruceB=1, CruceA=0, all lamps red and PendB=0. It then goes to VERDE_B.
5. rst=1 for one clk during AMARILLO_B → next clk shows VerdeA=1, cuenta=9, Pend*=0. The first tick arrives 4 clk after rst falls.
6. PasoA held across the ROJO_AB→PEATON edge, then released → CruceA=1 during PEATON and PendA=0 after that edge. A further PasoA press during PEATON gives PendA=1 and a second PEATON after ROJO_BA.
